// File: rtl/mcse_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mcse_bus_arbiter
//
// Round-robin arbiter that lets NREQ requesters share one boot-control bus
// engine. A request's address, payload and direction are captured when it is
// granted. The command goes to the engine as a single bus_go pulse. The
// engine's completion is returned to the granted requester as a one-cycle
// req_done pulse.
//
// Optional feature: define MCSE_ARB_TIMEOUT_EN to add a WAIT-state watchdog.
// If bus_done has not arrived after TIMEOUT_CYCLES WAIT cycles, the
// transaction ends with req_done and req_err together and req_rdata zero.
// Without the macro, WAIT lasts until bus_done and req_err is tied to zero.
//
// Ports
//   clk, rst_n    clock; asynchronous active-low reset
//   req_valid     per-requester request level, held until req_done
//   req_addr      packed request addresses (slice i = requester i)
//   req_wdata     packed write payloads (slice i = requester i)
//   req_rw        per-requester direction, 1 = write
//   req_done      one-cycle completion pulse to the granted requester
//   req_err       one-cycle error pulse, coincident with req_done
//   req_rdata     read data while req_done is high, zero otherwise
//   grant_id      current / most recent grant index
//   busy          high whenever the FSM is not IDLE
//   bus_go        one-cycle command strobe to the bus engine
//   bus_addr      latched address, held from ISSUE through RESP
//   bus_write     latched write payload, held from ISSUE through RESP
//   bus_RW        latched direction, held from ISSUE through RESP
//   bus_done      engine completion pulse (only honoured in WAIT)
//   bus_rdData    engine read data, valid with bus_done
// -----------------------------------------------------------------------------
module mcse_bus_arbiter #(
    parameter int NREQ               = 3,
    parameter int pAHB_ADDR_WIDTH    = 32,
    parameter int pPAYLOAD_SIZE_BITS = 256,
    parameter int TIMEOUT_CYCLES     = 1024,
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NREQ-1:0]                    req_valid,
    input  logic [NREQ*pAHB_ADDR_WIDTH-1:0]    req_addr,
    input  logic [NREQ*pPAYLOAD_SIZE_BITS-1:0] req_wdata,
    input  logic [NREQ-1:0]                    req_rw,
    output logic [NREQ-1:0]                    req_done,
    output logic [NREQ-1:0]                    req_err,
    output logic [pPAYLOAD_SIZE_BITS-1:0]      req_rdata,
    output logic [GW-1:0]                      grant_id,
    output logic                               busy,
    output logic                               bus_go,
    output logic [pAHB_ADDR_WIDTH-1:0]         bus_addr,
    output logic [pPAYLOAD_SIZE_BITS-1:0]      bus_write,
    output logic                               bus_RW,
    input  logic                               bus_done,
    input  logic [pPAYLOAD_SIZE_BITS-1:0]      bus_rdData
);

    localparam int AW = pAHB_ADDR_WIDTH;
    localparam int DW = pPAYLOAD_SIZE_BITS;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            rw_q, rw_d;
    logic [DW-1:0]   rdata_q, rdata_d;

`ifdef MCSE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    // Per-requester views of the packed request buses.
    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*AW +: AW];
        assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
    end

    // Only legal watchdog limits elaborate this (empty) block.
    if (TIMEOUT_CYCLES > 0) begin : g_timeout_limit_ok
    end

    // Round-robin pick: first set request bit above last_grant, wrapping.
    // Starting the search one past the previous winner is what keeps a
    // requester from winning twice in a row while others are waiting.
    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic [GW-1:0]   cand;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_grant_q) + k) % NREQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rw_d         = rw_q;
        rdata_d      = rdata_q;
`ifdef MCSE_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    addr_d  = addr_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    rw_d    = req_rw[pick_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rdata_d = '0;
`ifdef MCSE_ARB_TIMEOUT_EN
                cnt_d   = '0;
                err_d   = 1'b0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                // bus_done takes priority over a watchdog expiring in the same cycle.
                if (bus_done) begin
                    rdata_d = rw_q ? '0 : bus_rdData;
                    state_d = RESP;
                end
`ifdef MCSE_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NREQ - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rw_q         <= 1'b0;
            rdata_q      <= '0;
`ifdef MCSE_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rw_q         <= rw_d;
            rdata_q      <= rdata_d;
`ifdef MCSE_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    // Outputs are decoded from registered state only.
    assign busy      = (state_q != IDLE);
    assign bus_go    = (state_q == ISSUE);
    assign bus_addr  = addr_q;
    assign bus_write = wdata_q;
    assign bus_RW    = rw_q;
    assign grant_id  = grant_q;
    assign req_rdata = (state_q == RESP) ? rdata_q : '0;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
        assign req_done[gi] = (state_q == RESP) && (grant_q == GW'(gi));
`ifdef MCSE_ARB_TIMEOUT_EN
        assign req_err[gi]  = (state_q == RESP) && (grant_q == GW'(gi)) && err_q;
`else
        assign req_err[gi]  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mcse_bus_arbiter.sv
// Randomized scoreboard bench for mcse_bus_arbiter (NREQ=3, 32-bit addr,
// 256-bit payload, TIMEOUT_CYCLES=16).
module tb_mcse_bus_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 256;
    localparam int TO   = 16;
    localparam int GW   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_rw = '0;
    logic [AW-1:0]     addr_v  [NREQ];
    logic [DW-1:0]     wdata_v [NREQ];
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   req_done, req_err;
    logic [DW-1:0]     req_rdata;
    logic [GW-1:0]     grant_id;
    logic              busy, bus_go, bus_RW;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_write;
    logic              bus_done = 1'b0;
    logic [DW-1:0]     bus_rdData = '0;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = addr_v[i];
            req_wdata[i*DW +: DW] = wdata_v[i];
        end
    end

    mcse_bus_arbiter #(
        .NREQ(NREQ), .pAHB_ADDR_WIDTH(AW), .pPAYLOAD_SIZE_BITS(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rw(req_rw), .req_done(req_done), .req_err(req_err),
        .req_rdata(req_rdata), .grant_id(grant_id), .busy(busy), .bus_go(bus_go),
        .bus_addr(bus_addr), .bus_write(bus_write), .bus_RW(bus_RW),
        .bus_done(bus_done), .bus_rdData(bus_rdData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_payload();
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference arbitration rule: first pending requester after 'last', wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    typedef struct {
        int            id;
        logic [DW-1:0] rdata;
        logic          err;
    } resp_t;
    resp_t exp_q[$];

    // Reference model / monitor state
    bit              mon_en = 1'b0;
    bit              in_txn = 1'b0;
    int              cur_id = 0;
    logic [AW-1:0]   cur_addr;
    logic [DW-1:0]   cur_wdata;
    logic            cur_rw;
    int              model_last = NREQ - 1;
    bit [NREQ-1:0]   done_seen = '0;
    int              done_count = 0;
    int              go_count = 0;
    int              last_go_cyc = 0;
    int              last_done_cyc = 0;
    int              grant_log[$];
    logic [NREQ-1:0] prev_valid = '0;
    logic [NREQ-1:0] prev_rw = '0;
    logic [AW-1:0]   prev_addr  [NREQ];
    logic [DW-1:0]   prev_wdata [NREQ];

    // Bus engine model controls
    bit eng_on = 1'b0, eng_rand = 1'b0, stray_on = 1'b0, force_pulse = 1'b0;
    bit eng_busy = 1'b0;
    int eng_delay = 0;

    // Monitor: samples on the falling edge; prev_* hold the inputs that the
    // DUT saw on the rising edge just before this sample.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_go) begin
                int e;
                e = rr_pick(prev_valid, model_last);
                chk("single_go", DW'(in_txn), DW'(0));
                chk("grant", DW'(grant_id), DW'(e));
                if (e >= 0) begin
                    chk("go_addr",  DW'(bus_addr), DW'(prev_addr[e]));
                    chk("go_wdata", bus_write, prev_wdata[e]);
                    chk("go_rw",    DW'(bus_RW), DW'(prev_rw[e]));
                    cur_id    = e;
                    cur_addr  = prev_addr[e];
                    cur_wdata = prev_wdata[e];
                    cur_rw    = prev_rw[e];
                end
                grant_log.push_back(int'(grant_id));
                in_txn      = 1'b1;
                last_go_cyc = cyc;
                go_count++;
                if (eng_on) begin
                    eng_busy  = 1'b1;
                    eng_delay = eng_rand ? int'($urandom_range(0, 3)) : 0;
                end
            end else if (in_txn && req_done == '0) begin
                chk("hold_addr",  DW'(bus_addr), DW'(cur_addr));
                chk("hold_wdata", bus_write, cur_wdata);
                chk("hold_rw",    DW'(bus_RW), DW'(cur_rw));
                chk("busy_txn",   DW'(busy), DW'(1));
            end
            if (req_done != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got req_done=%b expected none", req_done);
                end else begin
                    resp_t r;
                    r = exp_q.pop_front();
                    chk("done_vec", DW'(req_done), DW'(1 << r.id));
                    chk("rdata", req_rdata, r.rdata);
                    chk("err_vec", DW'(req_err), r.err ? DW'(1 << r.id) : DW'(0));
                    $display("txn %0d: req=%0d rw=%0d addr=%08h err=%0d rdata=%0h",
                             done_count, r.id, cur_rw, cur_addr, req_err != '0, req_rdata);
                    done_seen[r.id] = 1'b1;
                    model_last = r.id;
                end
                done_count++;
                in_txn        = 1'b0;
                last_done_cyc = cyc;
            end else begin
                chk("rdata_zero", req_rdata, DW'(0));
                chk("err_zero", DW'(req_err), DW'(0));
            end
            if (in_txn && eng_on && (cyc - last_go_cyc > 40)) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got no req_done for req %0d expected one", cur_id);
                in_txn = 1'b0;
            end
        end
        prev_valid = req_valid;
        prev_rw    = req_rw;
        for (int i = 0; i < NREQ; i++) begin
            prev_addr[i]  = addr_v[i];
            prev_wdata[i] = wdata_v[i];
        end
    end

    // Bus engine: answers each bus_go after 0..3 WAIT cycles; may also emit
    // stray bus_done pulses while no command is outstanding.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus_done = 1'b0;
            if (eng_busy) begin
                if (eng_delay == 0) begin
                    bus_rdData = eng_rand ? rand_payload() : {32{8'hA5}};
                    bus_done   = 1'b1;
                    exp_q.push_back('{cur_id, cur_rw ? DW'(0) : bus_rdData, 1'b0});
                    eng_busy   = 1'b0;
                end else begin
                    eng_delay--;
                end
            end else if (force_pulse || (stray_on && $urandom_range(0, 7) == 0)) begin
                bus_rdData  = rand_payload();
                bus_done    = 1'b1;
                force_pulse = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  DW'(busy), DW'(0));
        chk({tag, "_go"},    DW'(bus_go), DW'(0));
        chk({tag, "_done"},  DW'(req_done), DW'(0));
        chk({tag, "_err"},   DW'(req_err), DW'(0));
        chk({tag, "_gid"},   DW'(grant_id), DW'(0));
        chk({tag, "_addr"},  DW'(bus_addr), DW'(0));
        chk({tag, "_write"}, bus_write, DW'(0));
        chk({tag, "_rw"},    DW'(bus_RW), DW'(0));
        chk({tag, "_rdata"}, req_rdata, DW'(0));
    endtask

    bit [NREQ-1:0] active = '0;
    int t0, gc0, dc0;

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            addr_v[i]  = '0;
            wdata_v[i] = '0;
        end
        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;

        // Single read by requester 1; engine answers in the first WAIT cycle.
        eng_on = 1'b1;
        eng_rand = 1'b0;
        tick();
        addr_v[1] = 32'h0000_1000;
        req_rw[1] = 1'b0;
        req_valid = 3'b010;
        t0  = cyc;
        gc0 = go_count;
        for (int w = 0; w < 20 && !done_seen[1]; w++) tick();
        chk("single_seen", DW'(done_seen[1]), DW'(1));
        // Request cycle plus ISSUE and WAIT: req_done falls in the 4th cycle.
        chk("single_latency", DW'(last_done_cyc - t0), DW'(3));
        chk("single_go_count", DW'(go_count - gc0), DW'(1));
        req_valid = '0;
        done_seen = '0;

        // Stray bus_done while idle must do nothing.
        tick();
        force_pulse = 1'b1;
        repeat (3) @(negedge clk);
        chk("stray_busy", DW'(busy), DW'(0));

        // Randomized traffic with withdrawals, late data changes and stray pulses.
        eng_rand = 1'b1;
        stray_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (done_seen[i]) begin
                    done_seen[i] = 1'b0;
                    active[i]    = 1'b0;
                    req_valid[i] = 1'b0;
                end else if (!active[i] && $urandom_range(0, 3) == 0) begin
                    active[i]    = 1'b1;
                    req_valid[i] = 1'b1;
                    addr_v[i]    = $urandom;
                    wdata_v[i]   = rand_payload();
                    req_rw[i]    = 1'($urandom_range(0, 1));
                end else if (active[i] && $urandom_range(0, 15) == 0) begin
                    if (in_txn && cur_id == i) req_valid[i] = 1'b0;
                    addr_v[i]  = $urandom;
                    wdata_v[i] = rand_payload();
                    req_rw[i]  = ~req_rw[i];
                end
            end
        end
        stray_on = 1'b0;
        for (int c = 0; c < 300 && (active != '0 || in_txn); c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (done_seen[i]) begin
                    done_seen[i] = 1'b0;
                    active[i]    = 1'b0;
                    req_valid[i] = 1'b0;
                end
            end
        end
        chk("drain_active", DW'(active), DW'(0));
        req_valid = '0;
        tick();

        // Engine silent: watchdog (if built) or indefinite WAIT.
        eng_on = 1'b0;
        done_seen = '0;
        addr_v[2] = 32'hCAFE_0002;
        req_rw[2] = 1'b0;
`ifdef MCSE_ARB_TIMEOUT_EN
        exp_q.push_back('{2, DW'(0), 1'b1});
        req_valid = 3'b100;
        for (int w = 0; w < 60 && !done_seen[2]; w++) tick();
        chk("timeout_seen", DW'(done_seen[2]), DW'(1));
        chk("timeout_latency", DW'(last_done_cyc - last_go_cyc), DW'(TO + 1));
        req_valid = '0;
        tick();
        req_valid = 3'b100;
        repeat (4) tick();
`else
        req_valid = 3'b100;
        repeat (40) tick();
        @(negedge clk);
        chk("stall_busy", DW'(busy), DW'(1));
        chk("stall_no_done", DW'(done_seen[2]), DW'(0));
`endif

        // Reset while in WAIT, then a late bus_done.
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        exp_q.delete();
        in_txn = 1'b0;
        model_last = NREQ - 1;
        done_seen = '0;
        mon_en = 1'b1;
        tick();
        force_pulse = 1'b1;
        repeat (3) @(negedge clk);
        chk("postrst_busy", DW'(busy), DW'(0));

        // All three held continuously: order 0,1,2,0 after reset.
        eng_on = 1'b1;
        grant_log.delete();
        dc0 = done_count;
        tick();
        for (int i = 0; i < NREQ; i++) begin
            addr_v[i]  = $urandom;
            wdata_v[i] = rand_payload();
            req_rw[i]  = 1'($urandom_range(0, 1));
        end
        req_valid = 3'b111;
        for (int w = 0; w < 100 && done_count < dc0 + 4; w++) tick();
        req_valid = '0;
        for (int w = 0; w < 20 && in_txn; w++) tick();
        chk("rr_count", DW'(grant_log.size()), DW'(4));
        if (grant_log.size() >= 4) begin
            chk("rr_0", DW'(grant_log[0]), DW'(0));
            chk("rr_1", DW'(grant_log[1]), DW'(1));
            chk("rr_2", DW'(grant_log[2]), DW'(2));
            chk("rr_3", DW'(grant_log[3]), DW'(0));
        end
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
